// File: rtl/sdm_core_if.sv
// Connects the register block's enable/value outputs to the sigma-delta modulator
// and carries the modulator's status back.
interface sdm_core_if;
  logic        enable;
  logic [31:0] value;
  logic        pdm_out;
  logic        pdm_tick;
  logic        frame_start;
  logic        running;

  modport master (
    output enable, value,
    input  pdm_out, pdm_tick, frame_start, running
  );

  modport slave (
    input  enable, value,
    output pdm_out, pdm_tick, frame_start, running
  );
endinterface

// File: rtl/sdm_core.sv
// First-order sigma-delta (PDM) modulator whose ones-density is value/2^DATA_W.
// New levels are latched only at frame boundaries so register writes never disturb a frame.
module sdm_core #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input logic       aclk,
  input logic       aresetn,
  sdm_core_if.slave bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] frame_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              pdm_out_q;
  logic              pdm_tick_q;
  logic              frame_start_q;
  logic              running_q;
  logic [DATA_W:0]   sum;
  logic              unused_value_hi;

  assign sum             = {1'b0, acc} + {1'b0, shadow};
  assign unused_value_hi = ^bus.value[31:DATA_W];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      acc           <= '0;
      shadow        <= '0;
      frame_cnt     <= '0;
      div_cnt       <= '0;
      pdm_out_q     <= 1'b0;
      pdm_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle; only a tick raises them.
      pdm_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      case (state)
        IDLE: begin
          pdm_out_q <= 1'b0;
          running_q <= 1'b0;
          acc       <= '0;
          div_cnt   <= '0;
          frame_cnt <= '0;
          if (bus.enable) state <= START;
        end
        START: begin
          if (bus.enable) begin
            shadow    <= bus.value[DATA_W-1:0];
            acc       <= '0;
            div_cnt   <= '0;
            frame_cnt <= '0;
            running_q <= 1'b1;
            state     <= RUN;
          end else begin
            running_q <= 1'b0;
            state     <= IDLE;
          end
        end
        RUN: begin
          if (!bus.enable) begin
            // Disable takes priority over a coincident tick.
            pdm_out_q <= 1'b0;
            running_q <= 1'b0;
            acc       <= '0;
            state     <= IDLE;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt       <= '0;
            pdm_out_q     <= sum[DATA_W];
            acc           <= sum[DATA_W-1:0];
            pdm_tick_q    <= 1'b1;
            frame_start_q <= (frame_cnt == '0);
            frame_cnt     <= frame_cnt + DATA_W'(1);
            // Last tick of the frame: the new level applies from the next frame.
            if (&frame_cnt) shadow <= bus.value[DATA_W-1:0];
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.pdm_out     = pdm_out_q;
  assign bus.pdm_tick    = pdm_tick_q;
  assign bus.frame_start = frame_start_q;
  assign bus.running     = running_q;

endmodule

// File: tb/tb_sdm_core.sv
// Directed bench for sdm_core: one instance at CLK_DIV=4 and one at CLK_DIV=1.
module tb_sdm_core;

  logic aclk;
  logic aresetn;
  logic rst1;

  sdm_core_if b0 ();
  sdm_core_if b1 ();

  sdm_core #(.DATA_W(8), .CLK_DIV(4)) u_dut  (.aclk(aclk), .aresetn(aresetn), .bus(b0.slave));
  sdm_core #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (.aclk(aclk), .aresetn(rst1),    .bus(b1.slave));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int   tests = 0;
  int   fails = 0;
  bit   timed_out = 0;
  int   stray_fs = 0;
  logic frame_bits [256];
  logic first_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    if (b0.frame_start === 1'b1 && b0.pdm_tick !== 1'b1) stray_fs++;
  endtask

  task automatic next_tick(output int gap, output logic out, output logic fs);
    gap = 0; out = 1'b0; fs = 1'b0;
    if (timed_out) return;
    do begin
      step();
      gap++;
    end while (b0.pdm_tick !== 1'b1 && gap < 64);
    if (b0.pdm_tick !== 1'b1) begin
      timed_out = 1;
      chk("tick_timeout", 32'(b0.pdm_tick), 32'd1);
    end
    out = b0.pdm_out;
    fs  = b0.frame_start;
  endtask

  // Runs one 256-tick frame; value is rewritten after tick chg_at (if >= 0).
  task automatic run_frame(input int chg_at, input logic [31:0] chg_val,
                           output int ones, output int fs_cnt, output int gap_bad,
                           output int first_gap);
    int   gap;
    logic out, fs;
    ones = 0; fs_cnt = 0; gap_bad = 0; first_gap = 0;
    for (int i = 0; i < 256; i++) begin
      next_tick(gap, out, fs);
      frame_bits[i] = out;
      ones   += int'(out);
      fs_cnt += int'(fs);
      if (i == 0) begin
        first_gap = gap;
        first_fs  = fs;
      end else if (gap != 4) begin
        gap_bad++;
      end
      if (i == chg_at) b0.value = chg_val;
    end
  endtask

  initial begin
    int   ones, fs_cnt, gap_bad, first_gap, pat_bad, tick_bad;
    logic [3:0] pat;

    aresetn = 1'b0; rst1 = 1'b0;
    b0.enable = 1'b1; b0.value = 32'h40;
    b1.enable = 1'b0; b1.value = 32'h0;

    // Test 1: reset holds everything low, then START/RUN latency
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_outputs", 32'({b0.pdm_out, b0.pdm_tick, b0.frame_start, b0.running}), 32'h0);
    end
    aresetn = 1'b1;
    step();
    chk("start_running", 32'(b0.running), 32'd0);
    step();
    chk("run_running", 32'(b0.running), 32'd1);
    chk("run_no_tick", 32'(b0.pdm_tick), 32'd0);

    // Test 2: value 0x40, pattern 0,0,0,1
    run_frame(-1, 32'h0, ones, fs_cnt, gap_bad, first_gap);
    chk("first_tick_latency", 32'(first_gap), 32'd4);
    chk("tick_period_0x40", 32'(gap_bad), 32'd0);
    pat_bad = 0;
    for (int i = 0; i < 256; i++) if (frame_bits[i] !== ((i % 4) == 3)) pat_bad++;
    chk("pattern_0x40", 32'(pat_bad), 32'd0);
    chk("ones_0x40", 32'(ones), 32'd64);
    chk("frame_start_count", 32'(fs_cnt), 32'd1);
    chk("frame_start_first", 32'(first_fs), 32'd1);

    // Test 3: mid-frame writes wait for the frame wrap
    b0.value = 32'h80;
    run_frame(-1, 32'h0, ones, fs_cnt, gap_bad, first_gap);
    chk("ones_before_0x80", 32'(ones), 32'd64);
    run_frame(100, 32'hC0, ones, fs_cnt, gap_bad, first_gap);
    chk("ones_0x80", 32'(ones), 32'd128);
    pat_bad = 0;
    for (int i = 0; i < 256; i++) if (frame_bits[i] !== ((i % 2) == 1)) pat_bad++;
    chk("pattern_0x80", 32'(pat_bad), 32'd0);
    chk("frame_start_0x80", 32'(first_fs), 32'd1);

    // Test 4: 0xC0, then zero for two frames, then 0x1FF truncated to 0xFF
    run_frame(100, 32'h00, ones, fs_cnt, gap_bad, first_gap);
    chk("ones_0xC0", 32'(ones), 32'd192);
    run_frame(-1, 32'h0, ones, fs_cnt, gap_bad, first_gap);
    chk("ones_zero_a", 32'(ones), 32'd0);
    run_frame(100, 32'h1FF, ones, fs_cnt, gap_bad, first_gap);
    chk("ones_zero_b", 32'(ones), 32'd0);
    run_frame(-1, 32'h0, ones, fs_cnt, gap_bad, first_gap);
    chk("ones_0xFF", 32'(ones), 32'd255);
    chk("zero_pos_0xFF", 32'(frame_bits[0]), 32'd0);
    chk("tick_period_0xFF", 32'(gap_bad), 32'd0);

    // Test 5: disable on a tick cycle, then re-enable at 0x40
    for (int i = 0; i < 3; i++) next_tick(first_gap, pat[0], pat[1]);
    chk("pre_disable_out", 32'(b0.pdm_out), 32'd1);
    step(); step(); step();
    b0.enable = 1'b0;
    step();
    chk("disable_outputs", 32'({b0.pdm_out, b0.pdm_tick, b0.frame_start, b0.running}), 32'h0);
    tick_bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (b0.pdm_tick !== 1'b0 || b0.running !== 1'b0) tick_bad++;
    end
    chk("idle_quiet", 32'(tick_bad), 32'd0);
    b0.value = 32'h40; b0.enable = 1'b1;
    run_frame(-1, 32'h0, ones, fs_cnt, gap_bad, first_gap);
    chk("reenable_latency", 32'(first_gap), 32'd6);
    chk("reenable_pattern", 32'({frame_bits[0], frame_bits[1], frame_bits[2], frame_bits[3]}), 32'b0001);
    chk("reenable_ones", 32'(ones), 32'd64);
    chk("reenable_fs", 32'(first_fs), 32'd1);
    chk("stray_frame_start", 32'(stray_fs), 32'd0);

    // Test 6: CLK_DIV=1 ticks every cycle; reset mid-frame restarts cleanly
    b1.enable = 1'b1; b1.value = 32'h40;
    step(); step();
    chk("div1_reset_outputs", 32'({b1.pdm_out, b1.pdm_tick, b1.frame_start, b1.running}), 32'h0);
    rst1 = 1'b1;
    step();
    chk("div1_start_running", 32'(b1.running), 32'd0);
    step();
    chk("div1_run", 32'({b1.running, b1.pdm_tick}), 32'b10);
    ones = 0; tick_bad = 0; fs_cnt = 0; first_gap = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (b1.pdm_tick !== 1'b1) tick_bad++;
      ones   += int'(b1.pdm_out);
      fs_cnt += int'(b1.frame_start);
      if (i == 0) first_gap = int'(b1.frame_start);
    end
    chk("div1_tick_every_cycle", 32'(tick_bad), 32'd0);
    chk("div1_ones", 32'(ones), 32'd64);
    chk("div1_fs", 32'({fs_cnt[7:0], first_gap[7:0]}), 32'h0101);
    repeat (100) step();
    rst1 = 1'b0;
    step();
    chk("div1_midreset", 32'({b1.pdm_out, b1.pdm_tick, b1.frame_start, b1.running}), 32'h0);
    rst1 = 1'b1;
    step();
    chk("div1_restart_start", 32'(b1.running), 32'd0);
    step();
    chk("div1_restart_run", 32'({b1.running, b1.pdm_tick}), 32'b10);
    step();
    chk("div1_restart_fs", 32'({b1.pdm_tick, b1.frame_start}), 32'b11);
    pat[3] = b1.pdm_out;
    step(); pat[2] = b1.pdm_out;
    step(); pat[1] = b1.pdm_out;
    step(); pat[0] = b1.pdm_out;
    chk("div1_restart_pattern", 32'(pat), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdm_core.md
Name: sdm_core

Overview:
First-order sigma-delta (PDM) modulator. It sits directly downstream of the AXI-Lite register block and consumes its `enable` and `value` outputs. It produces a 1-bit pulse-density stream whose ones-density equals value[DATA_W-1:0] / 2^DATA_W. New values take effect only on frame boundaries (2^DATA_W modulation ticks), so register writes never disturb a frame.

Parameters:
DATA_W, 8, number of used bits of `value` (modulator resolution); valid range 2..16.
CLK_DIV, 4, aclk cycles per modulation tick; must be >= 1.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset: synchronous, active-low; clock is aclk.
enable  in  1  1 = modulator running, 0 = stopped; driven by the register block.
value  in  32  input level; bits [DATA_W-1:0] used, bits [31:DATA_W] ignored.
pdm_out  out  1  modulator bit; updated only on ticks, held between ticks.
pdm_tick  out  1  one-cycle pulse, coincident with each pdm_out update.
frame_start  out  1  one-cycle pulse on the first tick of each frame.
running  out  1  1 while the FSM is in RUN.

Behaviour:
- Reset (aresetn=0 sampled at posedge): the following registers clear to 0 at that edge:
  - state = IDLE
  - pdm_out, pdm_tick, frame_start, running
  - acc[DATA_W-1:0], div_cnt, frame_cnt[DATA_W-1:0], shadow[DATA_W-1:0]
  Reset mid-operation behaves identically and has priority over everything.
- FSM states:
  - IDLE: all outputs 0, counters held at 0. enable=1 -> START.
  - START (exactly 1 cycle): shadow<=value[DATA_W-1:0], acc<=0, div_cnt<=0, frame_cnt<=0, running<=1; -> RUN. If enable=0 in START -> IDLE, running<=0.
  - RUN: if enable=0 -> IDLE at the next edge.
    - On that edge: pdm_out<=0, pdm_tick<=0, frame_start<=0, running<=0, acc<=0.
    - Disable wins over a coincident tick; no tick is produced.
    - Otherwise div_cnt increments each cycle.
    - When div_cnt==CLK_DIV-1, a tick occurs: div_cnt<=0, and:
      - sum = {1'b0,acc} + {1'b0,shadow} (DATA_W+1 bits)
      - pdm_out<=sum[DATA_W]; acc<=sum[DATA_W-1:0]
      - pdm_tick<=1; frame_start<=(frame_cnt==0)
      - frame_cnt<=frame_cnt+1, wrapping modulo 2^DATA_W
      - if frame_cnt==2^DATA_W-1: shadow<=value[DATA_W-1:0] (new value applies from the next frame's first tick)
  - pdm_tick and frame_start are 0 on all non-tick cycles.
- Latency: enable sampled high at edge k.
  - State is START after edge k and RUN after edge k+1; running=1 after edge k+1.
  - First tick registers at edge k+1+CLK_DIV; subsequent ticks every CLK_DIV cycles.
  - CLK_DIV=1 gives a tick every cycle from edge k+2.
- Accuracy: acc is not cleared at frame boundaries. With a constant shadow u, every frame contains exactly u ones.
  - u=0: pdm_out is constantly 0.
  - u=2^DATA_W-1: exactly one 0 per frame.
- `value` changes mid-frame are ignored until the frame wrap. Re-enable always restarts from acc=0, frame_cnt=0, with a fresh shadow.
- Purely synchronous; no combinational paths from inputs to outputs.

Test Plan:
1. aresetn=0 for 5 cycles with enable=1, value=0x40 -> all outputs 0 during reset. Release -> running=1 two edges later; first pdm_tick exactly CLK_DIV(=4) cycles after that.
2. DATA_W=8, CLK_DIV=4, value=0x40 -> pdm_tick every 4 cycles; pdm_out pattern 0,0,0,1 repeating; exactly 64 ones per 256 ticks; frame_start once per 256 ticks, on the first tick.
3. value=0x80 -> pdm_out alternates 0,1 (128 ones per frame). value changed to 0xC0 at tick 100 -> that frame still has 128 ones; the next frame has 192 ones.
4. value=0x00 -> pdm_out never 1 over 2 frames. value=0x1FF -> treated as 0xFF; 255 ones and one 0 per frame.
5. enable dropped mid-frame on a tick cycle -> next edge: running=0, pdm_out=0, no pdm_tick. Re-enable with value=0x40 -> pattern restarts 0,0,0,1 from the first tick.
6. CLK_DIV=1, value=0x40 -> pdm_tick high every cycle in RUN; 64 ones per 256 cycles; aresetn pulse mid-frame -> all outputs 0 on the next edge, then restart via START.
